// File: rtl/scalar_mult_sequencer_if.sv
// Launch/result bus between the scalar-multiplication sequencer
// and its point-addition and point-doubling units.
interface scalar_mult_sequencer_if #(
   parameter int N = 231
);
   logic         add_rst;
   logic [N-1:0] add_x1;
   logic [N-1:0] add_y1;
   logic [N-1:0] add_x2;
   logic [N-1:0] add_y2;
   logic [N-1:0] add_x3;
   logic [N-1:0] add_y3;
   logic         add_ready;
   logic         add_inf;
   logic         dbl_rst;
   logic [N-1:0] dbl_x;
   logic [N-1:0] dbl_y;
   logic [N-1:0] dbl_x3;
   logic [N-1:0] dbl_y3;
   logic         dbl_ready;
   logic         dbl_inf;

   modport master (
      output add_rst, add_x1, add_y1, add_x2, add_y2,
      input  add_x3, add_y3, add_ready, add_inf,
      output dbl_rst, dbl_x, dbl_y,
      input  dbl_x3, dbl_y3, dbl_ready, dbl_inf
   );

   modport slave (
      input  add_rst, add_x1, add_y1, add_x2, add_y2,
      output add_x3, add_y3, add_ready, add_inf,
      input  dbl_rst, dbl_x, dbl_y,
      output dbl_x3, dbl_y3, dbl_ready, dbl_inf
   );
endinterface

// File: rtl/scalar_mult_sequencer.sv
// Left-to-right double-and-add controller computing Q = k*P,
// covering infinity, P + (-P) and P + P around the slave units.
module scalar_mult_sequencer #(
   parameter int N = 231
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] k,
   input  logic [N-1:0] px,
   input  logic [N-1:0] py,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] qx,
   output logic [N-1:0] qy,
   output logic         q_inf,
   scalar_mult_sequencer_if.master unit
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [3:0] {
      IDLE, SCAN, NEXT, DBL_GO, DBL_WAIT,
      ADD_CHK, ADD_GO, ADD_WAIT, DONE
   } state_t;

   state_t state, state_nx;

   logic [N-1:0]  kr;
   logic [N-1:0]  pxr;
   logic [N-1:0]  pyr;
   logic [IW-1:0] idx;
   logic          via_dbl;

   logic bit_set;
   logic last;
   logic same_x;
   logic same_y;

   assign bit_set = kr[idx];
   assign last    = (idx == '0);
   assign same_x  = (qx == pxr);
   assign same_y  = (qy == pyr);

   assign unit.add_x1 = qx;
   assign unit.add_y1 = qy;
   assign unit.add_x2 = pxr;
   assign unit.add_y2 = pyr;
   assign unit.dbl_x  = qx;
   assign unit.dbl_y  = qy;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (start) state_nx = SCAN;
         SCAN: begin
            if (bit_set)   state_nx = NEXT;
            else if (last) state_nx = DONE;
         end
         NEXT:     state_nx = last ? DONE : DBL_GO;
         DBL_GO:   state_nx = DBL_WAIT;
         DBL_WAIT: begin
            if (unit.dbl_ready)
               state_nx = via_dbl ? NEXT : ADD_CHK;
         end
         ADD_CHK: begin
            if (!bit_set || q_inf)  state_nx = NEXT;
            else if (same_x)        state_nx = same_y ? DBL_GO : NEXT;
            else                    state_nx = ADD_GO;
         end
         ADD_GO:   state_nx = ADD_WAIT;
         ADD_WAIT: if (unit.add_ready) state_nx = NEXT;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE) && !reset;
      done         = (state == DONE) && !reset;
      unit.add_rst = reset || (state != ADD_WAIT);
      unit.dbl_rst = reset || (state != DBL_WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kr      <= '0;
         pxr     <= '0;
         pyr     <= '0;
         idx     <= '0;
         via_dbl <= 1'b0;
         qx      <= '0;
         qy      <= '0;
         q_inf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  kr      <= k;
                  pxr     <= px;
                  pyr     <= py;
                  idx     <= IW'(N - 1);
                  via_dbl <= 1'b0;
                  qx      <= '0;
                  qy      <= '0;
                  q_inf   <= 1'b1;
               end
            end
            SCAN: begin
               if (bit_set) begin
                  qx    <= pxr;
                  qy    <= pyr;
                  q_inf <= 1'b0;
               end else if (!last) begin
                  idx <= idx - IW'(1);
               end
            end
            NEXT: begin
               if (!last) begin
                  idx <= idx - IW'(1);
               end else if (q_inf) begin
                  qx <= '0;
                  qy <= '0;
               end
            end
            DBL_WAIT: begin
               if (unit.dbl_ready) begin
                  qx      <= unit.dbl_x3;
                  qy      <= unit.dbl_y3;
                  // doubling the point at infinity stays at infinity
                  q_inf   <= q_inf | unit.dbl_inf;
                  via_dbl <= 1'b0;
               end
            end
            ADD_CHK: begin
               if (bit_set) begin
                  if (q_inf) begin
                     qx    <= pxr;
                     qy    <= pyr;
                     q_inf <= 1'b0;
                  end else if (same_x && !same_y) begin
                     q_inf <= 1'b1;
                  end else if (same_x) begin
                     via_dbl <= 1'b1;
                  end
               end
            end
            ADD_WAIT: begin
               if (unit.add_ready) begin
                  qx    <= unit.add_x3;
                  qy    <= unit.add_y3;
                  q_inf <= unit.add_inf;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/scalar_mult_sequencer.md
# scalar_mult_sequencer

Left-to-right double-and-add controller that computes Q = k·P on a short-Weierstrass curve. It drives the point-addition stage and the point-doubling stage as slave units: it launches each unit with a reset pulse and consumes its (x3, y3, ready, infinity) result. It also handles the group-law special cases those units do not cover: point at infinity, P + (−P), and P + P. It sits directly above point_addition in the scalar-multiplication datapath.

## Interface
- N, 231, coordinate and scalar width in bits
- clk  in  1  rising-edge clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- k  in  N  scalar; latched on accepted start
- px, py  in  N  base point P (affine, reduced mod p); latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the result is valid
- qx, qy  out  N  result coordinates; valid when q_inf = 0
- q_inf  out  1  result is the point at infinity
- add_rst  out  1  reset/launch for the addition unit
- add_x1, add_y1, add_x2, add_y2  out  N  addition operands (Q, P)
- add_x3, add_y3  in  N  addition result
- add_ready, add_inf  in  1  addition result valid / x-difference zero
- dbl_rst  out  1  reset/launch for the doubling unit
- dbl_x, dbl_y  out  N  doubling operand (Q)
- dbl_x3, dbl_y3  in  N  doubling result
- dbl_ready, dbl_inf  in  1  doubling result valid / y operand zero

## Operation
- Registers: kr, pxr, pyr, Q = (qx, qy, q_inf), index idx (ceil(log2 N) bits), and the flag via_dbl.
- Unit contract: each unit's ready is 0 the cycle after its rst is high. Operands must stay stable from the launch cycle until ready is sampled high.
- add_x1/add_y1 = qx/qy, add_x2/add_y2 = pxr/pyr, and dbl_x/dbl_y = qx/qy at all times.
- add_rst and dbl_rst are 1 during reset and in every state except their own WAIT state.
- States:
  - IDLE: on start, latch k, px, py; idx = N−1; q_inf = 1; go to SCAN.
  - SCAN (one bit per cycle, leading zeros skipped):
    - if kr[idx] = 1: Q = P, q_inf = 0, go to NEXT;
    - else if idx = 0: go to DONE with q_inf = 1;
    - else idx−−.
  - NEXT: if idx = 0, go to DONE; else idx−−, go to DBL_GO.
  - DBL_GO: dbl_rst = 1 (launch); go to DBL_WAIT.
  - DBL_WAIT: dbl_rst = 0; wait for dbl_ready.
    - On dbl_ready: Q = (dbl_x3, dbl_y3) and q_inf = dbl_inf.
    - If via_dbl: clear via_dbl, go to NEXT. Otherwise go to ADD_CHK.
  - ADD_CHK:
    - if kr[idx] = 0: go to NEXT;
    - if q_inf: Q = P, q_inf = 0, go to NEXT;
    - if qx = pxr and qy ≠ pyr: q_inf = 1, go to NEXT;
    - if qx = pxr and qy = pyr: via_dbl = 1, go to DBL_GO;
    - else go to ADD_GO.
  - ADD_GO: add_rst = 1; go to ADD_WAIT.
  - ADD_WAIT: add_rst = 0; on add_ready, Q = (add_x3, add_y3), q_inf = 0, go to NEXT.
    - add_inf is not expected here (ADD_CHK screens it); if it is seen, set q_inf = 1 and go to NEXT.
  - DONE: done = 1 for one cycle; go to IDLE.
- When q_inf = 1 at any loop point, qx/qy are don't-care internally. At DONE with q_inf = 1, qx = qy = 0.

## Timing
- Reset values: qx = qy = 0, q_inf = 0, busy = 0, done = 0, add_rst = dbl_rst = 1, state = IDLE.
- Reset mid-operation: abort immediately (next edge IDLE). No done pulse, and the partial Q is discarded.
- start while busy or in DONE: ignored, no queueing.
- start and reset in the same cycle: reset wins.
- Latency from start to done:
  - 1 (IDLE→SCAN) + (leading zeros + 1) SCAN cycles, plus per remaining bit:
  - 1 NEXT + 2 + Ld doubling + 1 ADD_CHK, and, if the bit is set and a real add occurs, 2 + La.
  - Ld and La are the unit latencies measured from the rst deassertion cycle to the ready cycle.
- k = 0: done at cycle N+2 after start, with q_inf = 1.
- qx/qy/q_inf hold their value after done until the next accepted start.

## Test plan
Curve y² = x³ + 2x + 2 mod 17, P = (5,1), order 19, N = 8. Real point_addition instance plus a doubling model with Ld = 5.
- k = 0 → done with q_inf = 1, exactly 10 cycles after start; no unit launched (add_rst and dbl_rst stay 1).
- k = 1 → (5,1), q_inf = 0; no unit launched.
- k = 9 → (7,6); k = 10 → (7,11). Check done is a single-cycle pulse and busy falls together with done.
- k = 19 → q_inf = 1 through the P + (−P) branch at the last bit: Q = 18P = (5,16), and add_rst never drops for that bit.
- k = 21 → (6,3) through the equal-point branch: 20P = P, so via_dbl is set and dbl_rst pulses twice for bit 0.
- Reset asserted during DBL_WAIT of k = 9 → next cycle outputs at reset values and state IDLE. A following start with k = 3 → (10,6).
